// File: rtl/div_timer.sv
// Free-running clock divider with DIV/TIMA/TMA/TAC timer registers and a delayed TIMA reload.
// Register writes land on the next CLK edge; TIMA reload and INT_TIMER follow overflow by four CLK_ENA cycles.
module div_timer #(
  parameter int CNT_W = 18
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLK_ENA,
  input  logic       SEL,
  input  logic       WR,
  input  logic [1:0] ADDR,
  input  logic [7:0] DIN,
  output logic [7:0] DOUT,
  output logic       SIXTEEN_HZ,
  output logic       INT_TIMER
);

  typedef enum logic [1:0] {IDLE, OVF, RELOAD} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       tima, tima_nxt;
  logic [7:0]       tma, tma_nxt;
  logic [2:0]       tac;
  logic [1:0]       ovf_cnt, ovf_cnt_nxt;
  logic [7:0]       div_reg;
  logic             tap_bit, tap, tap_q, tick;
  logic             wr_div, wr_tima, wr_tma, wr_tac;

  assign wr_div  = SEL & WR & (ADDR == 2'd0);
  assign wr_tima = SEL & WR & (ADDR == 2'd1);
  assign wr_tma  = SEL & WR & (ADDR == 2'd2);
  assign wr_tac  = SEL & WR & (ADDR == 2'd3);

  // Narrow divider builds read the missing upper DIV bits as zero.
  generate
    if (CNT_W >= 16) begin : g_div_wide
      assign div_reg = cnt[15:8];
    end else begin : g_div_narrow
      assign div_reg = 8'(cnt[CNT_W-1:8]);
    end
  endgenerate

  always_comb begin
    tap_bit = cnt[9];
    case (tac[1:0])
      2'b00: tap_bit = cnt[9];
      2'b01: tap_bit = cnt[3];
      2'b10: tap_bit = cnt[5];
      2'b11: tap_bit = cnt[7];
      default: tap_bit = cnt[9];
    endcase
  end

  // Any drop of the gated tap counts, including ones caused by DIV or TAC writes.
  assign tap     = tac[2] & tap_bit;
  assign tick    = CLK_ENA & tap_q & ~tap;
  assign tma_nxt = wr_tma ? DIN : tma;

  always_comb begin
    state_nxt   = state;
    tima_nxt    = tima;
    ovf_cnt_nxt = ovf_cnt;
    case (state)
      IDLE: begin
        if (wr_tima) begin
          tima_nxt = DIN;
        end else if (tick) begin
          if (tima == 8'hFF) begin
            tima_nxt    = 8'h00;
            state_nxt   = OVF;
            ovf_cnt_nxt = 2'd0;
          end else begin
            tima_nxt = tima + 8'd1;
          end
        end
      end
      OVF: begin
        if (wr_tima) begin
          tima_nxt  = DIN;
          state_nxt = IDLE;
        end else if (CLK_ENA) begin
          if (tick) tima_nxt = tima + 8'd1;
          if (ovf_cnt == 2'd3) begin
            tima_nxt  = tma_nxt;
            state_nxt = RELOAD;
          end else begin
            ovf_cnt_nxt = ovf_cnt + 2'd1;
          end
        end
      end
      RELOAD: begin
        // TIMA tracks TMA for this one cycle; CPU TIMA writes lose.
        tima_nxt  = tma_nxt;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt     <= '0;
      tima    <= 8'h00;
      tma     <= 8'h00;
      tac     <= 3'b000;
      state   <= IDLE;
      ovf_cnt <= 2'd0;
      tap_q   <= 1'b0;
    end else begin
      if (wr_div) begin
        cnt <= '0;
      end else if (CLK_ENA) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (CLK_ENA) tap_q <= tap;
      if (wr_tac) tac <= DIN[2:0];
      tma     <= tma_nxt;
      tima    <= tima_nxt;
      state   <= state_nxt;
      ovf_cnt <= ovf_cnt_nxt;
    end
  end

  always_comb begin
    DOUT = div_reg;
    case (ADDR)
      2'd0: DOUT = div_reg;
      2'd1: DOUT = tima;
      2'd2: DOUT = tma;
      2'd3: DOUT = {5'b11111, tac};
      default: DOUT = div_reg;
    endcase
  end

  assign SIXTEEN_HZ = cnt[CNT_W-1];
  assign INT_TIMER  = (state == RELOAD);

endmodule

// File: doc/div_timer.md
DIV_TIMER -- requirements
Module: div_timer

Interface
REQ-001 SHALL have parameter CNT_W, default 18: width of the free-running divider counter (min 10).
REQ-002 SHALL have port CLK, input, 1: 4 MHz system clock; all state updates on rising edge.
REQ-003 SHALL have port RESET, input, 1: asynchronous, active-high reset; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port CLK_ENA, input, 1: tick enable; divider and timer advance only in cycles where CLK_ENA=1.
REQ-005 SHALL have port SEL, input, 1: register access select.
REQ-006 SHALL have port WR, input, 1: write strobe, qualified by SEL, taken on the rising CLK edge regardless of CLK_ENA.
REQ-007 SHALL have port ADDR, input, 2: register index (0=DIV, 1=TIMA, 2=TMA, 3=TAC).
REQ-008 SHALL have port DIN, input, 8: write data.
REQ-009 SHALL have port DOUT, output, 8: read data, combinational from ADDR.
REQ-010 SHALL have port SIXTEEN_HZ, output, 1: divider bit CNT_W-1, feeding the oscillator-stable logic of the clock block.
REQ-011 SHALL have port INT_TIMER, output, 1: timer interrupt request, one-CLK pulse.

Function
REQ-012 SHALL keep counter cnt[CNT_W-1:0], incrementing by 1 mod 2^CNT_W per CLK_ENA cycle.
REQ-013 SHALL return cnt[15:8] on DOUT when ADDR=0.
REQ-014 SHALL clear all of cnt on any write with ADDR=0, independent of DIN and CLK_ENA.
REQ-015 SHALL hold TIMA, TMA (8 bits each) and TAC (3 bits); TAC[2]=enable, TAC[1:0] selects tap bit: 00->cnt[9], 01->cnt[3], 10->cnt[5], 11->cnt[7].
REQ-016 SHALL form tap = TAC[2] & cnt[selected bit], register it each CLK, and increment TIMA in the cycle after a 1->0 transition of tap.
REQ-017 SHALL treat as falling edges any tap drop caused by a DIV write, a TAC enable clear or a TAC select change (DMG glitch behaviour).
REQ-018 SHALL on TIMA increment from 0xFF set TIMA=0x00 and enter state OVF for 4 CLK_ENA cycles.
REQ-019 SHALL at the end of OVF (state RELOAD) load TIMA<=TMA and assert INT_TIMER for exactly one CLK, then return to IDLE.
REQ-020 SHALL have states IDLE, OVF, RELOAD; IDLE->OVF on overflow; OVF->RELOAD after 4th CLK_ENA cycle; RELOAD->IDLE unconditionally.
REQ-021 SHALL cancel a pending reload and interrupt when TIMA is written during OVF (IDLE, TIMA=DIN).
REQ-022 SHALL ignore TIMA writes in the RELOAD cycle (TMA value wins).
REQ-023 SHALL load the newly written TMA value into TIMA when TMA is written in the RELOAD cycle.
REQ-024 SHALL give a CPU TIMA write priority over a same-cycle increment (increment lost).
REQ-025 SHALL return TIMA, TMA, and {5'b11111,TAC} on DOUT for ADDR=1,2,3.
REQ-026 SHALL hold all state when CLK_ENA=0, except register writes (REQ-006).

Reset
REQ-027 SHALL on RESET=1, asynchronously: cnt=0, TIMA=0, TMA=0, TAC=0, state=IDLE, tap register=0, INT_TIMER=0, SIXTEEN_HZ=0.
REQ-028 SHALL abort any OVF/RELOAD in progress on RESET, with no INT_TIMER pulse.
REQ-029 SHALL resume counting on the first CLK_ENA cycle after RESET falls.

Verification
REQ-030 DIV: CLK_ENA=1 for 256 cycles after reset -> DOUT(ADDR=0)=0x01; then write DIV=0xAB -> reads 0x00 next cycle.
REQ-031 Timer: TAC=0x05, TMA=0x10, TIMA=0xFE -> after 32 cycles TIMA=0x00 for 4 cycles, then 0x10 and one INT_TIMER pulse.
REQ-032 Cancel: overflow as above, write TIMA=0x55 in 2nd OVF cycle -> TIMA=0x55, no INT_TIMER.
REQ-033 Glitch: TAC=0x05, wait until cnt[3]=1, write DIV -> TIMA +1 on next cycle.
REQ-034 SIXTEEN_HZ: CNT_W=18, CLK_ENA=1 -> first rise after 2^17 cycles, period 2^18 cycles.
REQ-035 Reset mid-OVF: assert RESET during OVF -> all registers 0, no INT_TIMER, counting resumes from 0.
